// File: rtl/buffer_slot_ctrl_if.sv
// buffer_slot_ctrl_if
//   Bundles every non-clock signal of buffer_slot_ctrl.
//   slave  : the controller's view (event pulses in, slot/status out).
//   master : the host/transactor view (drives pulses, observes status).
//   Signals:
//     h2c_dsc_done/h2c_len       request written into wr_slot
//     wr_slot/wr_base            next H2C target slot and its word base address
//     buf_full/occupancy         fill status (occupancy = slots not FREE)
//     ipb_pkt_rdy/ipb_slot/ipb_len, ipb_pkt_done/ipb_resp_len
//       Handshake: ipb_pkt_rdy is a registered level that holds slot/len stable
//       until the transactor pulses ipb_pkt_done; a pulse while ipb_pkt_rdy is
//       low is a protocol error. c2h_rdy/c2h_dsc_done follow the same rule.
//     c2h_rdy/c2h_slot/c2h_len, c2h_dsc_done  response readback
//     err_clr, overflow_err/proto_err/timeout_err  sticky error flags
//     ipb_fsm_state              debug view of the presentation FSM state
interface buffer_slot_ctrl_if #(
   parameter int NSLOTS  = 4,
   parameter int SLOT_AW = 10,
   parameter int LEN_W   = 11
);
   localparam int SW = $clog2(NSLOTS);

   logic              h2c_dsc_done;
   logic [LEN_W-1:0]  h2c_len;
   logic [SW-1:0]     wr_slot;
   logic [SW+SLOT_AW-1:0] wr_base;
   logic              buf_full;
   logic              ipb_pkt_rdy;
   logic [SW-1:0]     ipb_slot;
   logic [LEN_W-1:0]  ipb_len;
   logic              ipb_pkt_done;
   logic [LEN_W-1:0]  ipb_resp_len;
   logic              c2h_rdy;
   logic [SW-1:0]     c2h_slot;
   logic [LEN_W-1:0]  c2h_len;
   logic              c2h_dsc_done;
   logic [SW:0]       occupancy;
   logic              err_clr;
   logic              overflow_err;
   logic              proto_err;
   logic              timeout_err;
   logic              ipb_fsm_state;

   modport slave (
      input  h2c_dsc_done, h2c_len, ipb_pkt_done, ipb_resp_len, c2h_dsc_done, err_clr,
      output wr_slot, wr_base, buf_full, ipb_pkt_rdy, ipb_slot, ipb_len,
             c2h_rdy, c2h_slot, c2h_len, occupancy,
             overflow_err, proto_err, timeout_err, ipb_fsm_state
   );

   modport master (
      output h2c_dsc_done, h2c_len, ipb_pkt_done, ipb_resp_len, c2h_dsc_done, err_clr,
      input  wr_slot, wr_base, buf_full, ipb_pkt_rdy, ipb_slot, ipb_len,
             c2h_rdy, c2h_slot, c2h_len, occupancy,
             overflow_err, proto_err, timeout_err, ipb_fsm_state
   );
endinterface

// File: rtl/buffer_slot_ctrl.sv
// buffer_slot_ctrl
//   Ring of NSLOTS packet slots, each FREE -> REQ -> BUSY -> RESP -> FREE.
//   Three pointers (write, transactor, readback) walk the ring in order; at
//   most one slot is presented to the transactor at a time.
//   Ports:
//     user_clk   clock, rising edge
//     sys_rst_n  asynchronous active-low reset
//     bus        buffer_slot_ctrl_if.slave (all handshake/status signals)
//   Optional feature: define BUFFER_SLOT_TIMEOUT_EN to add a watchdog that
//   forces a stuck BUSY slot to RESP with length 0 and raises timeout_err.
module buffer_slot_ctrl #(
   parameter int NSLOTS    = 4,
   parameter int SLOT_AW   = 10,
   parameter int LEN_W     = 11,
   parameter int TIMEOUT_W = 16
) (
   input logic               user_clk,
   input logic               sys_rst_n,
   buffer_slot_ctrl_if.slave bus
);
   localparam int SW = $clog2(NSLOTS);
   localparam int PW = SW + 1;

   typedef enum logic [1:0] {
      SLOT_FREE = 2'd0,
      SLOT_REQ  = 2'd1,
      SLOT_BUSY = 2'd2,
      SLOT_RESP = 2'd3
   } slot_st_t;

   typedef enum logic {
      IPB_IDLE    = 1'b0,
      IPB_PRESENT = 1'b1
   } ipb_st_t;

   slot_st_t         r_slot_st  [NSLOTS];
   logic [LEN_W-1:0] r_slot_len [NSLOTS];
   logic [PW-1:0]    r_wr_ptr, r_ipb_ptr, r_c2h_ptr;
   ipb_st_t          r_ipb_st;
   logic             r_buf_full;
   logic             r_c2h_rdy;
   logic [LEN_W-1:0] r_c2h_len;
   logic [SW-1:0]    r_ipb_slot;
   logic [LEN_W-1:0] r_ipb_len;
   logic             r_overflow_err;
   logic             r_proto_err;

   ipb_st_t          w_ipb_st_nxt;
   slot_st_t         w_slot_st_nxt  [NSLOTS];
   logic [LEN_W-1:0] w_slot_len_nxt [NSLOTS];
   logic [SW-1:0]    w_wr_idx, w_ipb_idx, w_c2h_idx, w_c2h_idx_nxt;
   logic [PW-1:0]    w_wr_ptr_nxt, w_ipb_ptr_nxt, w_c2h_ptr_nxt, w_occ_nxt;
   logic             w_h2c_acc, w_h2c_drop;
   logic             w_ipb_acc, w_ipb_bad, w_ipb_start, w_ipb_fin;
   logic             w_c2h_acc, w_c2h_bad;
   logic             w_timeout;
   logic [LEN_W-1:0] w_fin_len;

   assign w_wr_idx  = r_wr_ptr[SW-1:0];
   assign w_ipb_idx = r_ipb_ptr[SW-1:0];
   assign w_c2h_idx = r_c2h_ptr[SW-1:0];

   // Full is judged on the registered flag, so a same-cycle readback never
   // makes room for an incoming request.
   assign w_h2c_acc  = bus.h2c_dsc_done & ~r_buf_full;
   assign w_h2c_drop = bus.h2c_dsc_done &  r_buf_full;
   assign w_ipb_acc  = bus.ipb_pkt_done & (r_ipb_st == IPB_PRESENT);
   assign w_ipb_bad  = bus.ipb_pkt_done & (r_ipb_st != IPB_PRESENT);
   assign w_c2h_acc  = bus.c2h_dsc_done &  r_c2h_rdy;
   assign w_c2h_bad  = bus.c2h_dsc_done & ~r_c2h_rdy;

   // A watchdog expiry completes the presented slot exactly like a done pulse.
   assign w_ipb_fin   = w_ipb_acc | w_timeout;
   assign w_fin_len   = w_timeout ? '0 : bus.ipb_resp_len;
   assign w_ipb_start = (r_ipb_st == IPB_IDLE) && (r_slot_st[w_ipb_idx] == SLOT_REQ);

   // Presentation FSM: state register
   always_ff @(posedge user_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_ipb_st <= IPB_IDLE;
      else            r_ipb_st <= w_ipb_st_nxt;
   end

   // Presentation FSM: next state. Returning to IDLE for one cycle after each
   // completion gives the mandatory low gap on ipb_pkt_rdy.
   always_comb begin
      w_ipb_st_nxt = r_ipb_st;
      case (r_ipb_st)
         IPB_IDLE:    if (w_ipb_start) w_ipb_st_nxt = IPB_PRESENT;
         IPB_PRESENT: if (w_ipb_fin)   w_ipb_st_nxt = IPB_IDLE;
         default:     w_ipb_st_nxt = IPB_IDLE;
      endcase
   end

   // Presentation FSM: outputs (decoded straight from the state register)
   always_comb begin
      bus.ipb_pkt_rdy   = (r_ipb_st == IPB_PRESENT);
      bus.ipb_fsm_state = r_ipb_st;
   end

   // Slot table next state. The three events always hit distinct slots: the
   // write slot is FREE, the presented slot REQ/BUSY, the readback slot RESP.
   always_comb begin
      for (int i = 0; i < NSLOTS; i++) begin
         w_slot_st_nxt[i]  = r_slot_st[i];
         w_slot_len_nxt[i] = r_slot_len[i];
      end
      if (w_h2c_acc) begin
         w_slot_st_nxt[w_wr_idx]  = SLOT_REQ;
         w_slot_len_nxt[w_wr_idx] = bus.h2c_len;
      end
      if (w_ipb_start) w_slot_st_nxt[w_ipb_idx] = SLOT_BUSY;
      if (w_ipb_fin) begin
         w_slot_st_nxt[w_ipb_idx]  = SLOT_RESP;
         w_slot_len_nxt[w_ipb_idx] = w_fin_len;
      end
      if (w_c2h_acc) w_slot_st_nxt[w_c2h_idx] = SLOT_FREE;
   end

   assign w_wr_ptr_nxt  = r_wr_ptr  + PW'(w_h2c_acc);
   assign w_ipb_ptr_nxt = r_ipb_ptr + PW'(w_ipb_fin);
   assign w_c2h_ptr_nxt = r_c2h_ptr + PW'(w_c2h_acc);
   assign w_occ_nxt     = w_wr_ptr_nxt - w_c2h_ptr_nxt;
   assign w_c2h_idx_nxt = w_c2h_ptr_nxt[SW-1:0];

   always_ff @(posedge user_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < NSLOTS; i++) begin
            r_slot_st[i]  <= SLOT_FREE;
            r_slot_len[i] <= '0;
         end
         r_wr_ptr       <= '0;
         r_ipb_ptr      <= '0;
         r_c2h_ptr      <= '0;
         r_buf_full     <= 1'b0;
         r_c2h_rdy      <= 1'b0;
         r_c2h_len      <= '0;
         r_ipb_slot     <= '0;
         r_ipb_len      <= '0;
         r_overflow_err <= 1'b0;
         r_proto_err    <= 1'b0;
      end else begin
         for (int i = 0; i < NSLOTS; i++) begin
            r_slot_st[i]  <= w_slot_st_nxt[i];
            r_slot_len[i] <= w_slot_len_nxt[i];
         end
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_ipb_ptr  <= w_ipb_ptr_nxt;
         r_c2h_ptr  <= w_c2h_ptr_nxt;
         r_buf_full <= (w_occ_nxt == PW'(NSLOTS));
         // Readback status looks ahead at the post-edge slot table so c2h_rdy
         // is a clean register yet rises on the same edge the slot turns RESP.
         r_c2h_rdy  <= (w_slot_st_nxt[w_c2h_idx_nxt] == SLOT_RESP);
         r_c2h_len  <= w_slot_len_nxt[w_c2h_idx_nxt];
         if (w_ipb_start) begin
            r_ipb_slot <= w_ipb_idx;
            r_ipb_len  <= r_slot_len[w_ipb_idx];
         end
         // Error events take priority over a same-cycle clear.
         if (w_h2c_drop)                r_overflow_err <= 1'b1;
         else if (bus.err_clr)          r_overflow_err <= 1'b0;
         if (w_ipb_bad || w_c2h_bad)    r_proto_err    <= 1'b1;
         else if (bus.err_clr)          r_proto_err    <= 1'b0;
      end
   end

`ifdef BUFFER_SLOT_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] r_wd_cnt;
   logic                 r_timeout_err;

   // Expires when the presented request has waited until the counter saturates.
   assign w_timeout = (r_ipb_st == IPB_PRESENT) && !bus.ipb_pkt_done && (&r_wd_cnt);

   always_ff @(posedge user_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if ((r_ipb_st == IPB_PRESENT) && !w_ipb_fin) r_wd_cnt <= r_wd_cnt + TIMEOUT_W'(1);
         else                                         r_wd_cnt <= '0;
         if (w_timeout)        r_timeout_err <= 1'b1;
         else if (bus.err_clr) r_timeout_err <= 1'b0;
      end
   end

   assign bus.timeout_err = r_timeout_err;
`else
   assign w_timeout = 1'b0;
   // Watchdog compiled out: the flag is tied low (TIMEOUT_W is always >= 1).
   assign bus.timeout_err = (TIMEOUT_W < 1);
`endif

   assign bus.wr_slot      = w_wr_idx;
   assign bus.wr_base      = {w_wr_idx, {SLOT_AW{1'b0}}};
   assign bus.buf_full     = r_buf_full;
   assign bus.ipb_slot     = r_ipb_slot;
   assign bus.ipb_len      = r_ipb_len;
   assign bus.c2h_rdy      = r_c2h_rdy;
   assign bus.c2h_slot     = w_c2h_idx;
   assign bus.c2h_len      = r_c2h_len;
   assign bus.occupancy    = r_wr_ptr - r_c2h_ptr;
   assign bus.overflow_err = r_overflow_err;
   assign bus.proto_err    = r_proto_err;
endmodule

// File: tb/tb_buffer_slot_ctrl.sv
// tb_buffer_slot_ctrl
//   Directed bench for buffer_slot_ctrl (NSLOTS 4, SLOT_AW 10, LEN_W 11).
//   A vector table drives one cycle per record and compares the full output
//   bundle after the edge; hand-written sequences cover reset, ring wrap and
//   (when BUFFER_SLOT_TIMEOUT_EN is defined) the watchdog.
module tb_buffer_slot_ctrl;
  localparam int OBS_W = 49;

  logic user_clk;
  logic sys_rst_n;

  buffer_slot_ctrl_if #(.NSLOTS(4), .SLOT_AW(10), .LEN_W(11)) bus ();

  buffer_slot_ctrl #(.NSLOTS(4), .SLOT_AW(10), .LEN_W(11), .TIMEOUT_W(4)) dut (
    .user_clk  (user_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  // clock / reset
  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit act=running req=finished");
    $fatal(1);
  end

  typedef struct {
    logic        h;
    logic [10:0] hl;
    logic        p;
    logic [10:0] rl;
    logic        c;
    logic        clr;
    logic [1:0]  wr;
    logic        full;
    logic        rdy;
    logic [1:0]  islot;
    logic [10:0] ilen;
    logic        crdy;
    logic [1:0]  cslot;
    logic [10:0] clen;
    logic [2:0]  occ;
    logic        ovf;
    logic        prt;
  } vec_t;

  vec_t vecs[$];
  logic [OBS_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard
  function automatic logic [OBS_W-1:0] pack(logic [1:0] wr, logic [11:0] wbase, logic full,
      logic rdy, logic [1:0] islot, logic [10:0] ilen, logic crdy, logic [1:0] cslot,
      logic [10:0] clen, logic [2:0] occ, logic ovf, logic prt, logic tmo);
    return {wr, wbase, full, rdy, islot, ilen, crdy, cslot, clen, occ, ovf, prt, tmo};
  endfunction

  // Slot/length of an idle presentation or readback are don't-care; the
  // expected ready bit decides whether they are compared.
  function automatic logic [OBS_W-1:0] observe(logic use_ipb, logic use_c2h);
    return pack(bus.wr_slot, bus.wr_base, bus.buf_full, bus.ipb_pkt_rdy,
                use_ipb ? bus.ipb_slot : 2'd0, use_ipb ? bus.ipb_len : 11'd0,
                bus.c2h_rdy, bus.c2h_slot, use_c2h ? bus.c2h_len : 11'd0,
                bus.occupancy, bus.overflow_err, bus.proto_err, bus.timeout_err);
  endfunction

  task automatic check_word(input string name, input logic [OBS_W-1:0] act);
    logic [OBS_W-1:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d req=%0d", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic h, input logic [10:0] hl, input logic p,
                       input logic [10:0] rl, input logic c, input logic clr);
    bus.h2c_dsc_done = h;
    bus.h2c_len      = hl;
    bus.ipb_pkt_done = p;
    bus.ipb_resp_len = rl;
    bus.c2h_dsc_done = c;
    bus.err_clr      = clr;
  endtask

  task automatic cycle(input logic h, input logic [10:0] hl, input logic p,
                       input logic [10:0] rl, input logic c, input logic clr);
    drive(h, hl, p, rl, c, clr);
    @(posedge user_clk);
    #1;
    drive(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b0);
    sys_rst_n = 1'b0;
    repeat (2) @(posedge user_clk);
    #1;
    sys_rst_n = 1'b1;
    @(posedge user_clk);
    #1;
  endtask

  task automatic wait_rdy(input string name);
    for (int t = 0; t < 8 && !bus.ipb_pkt_rdy; t++) cycle(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b0);
    check_val(name, {31'd0, bus.ipb_pkt_rdy}, 32'd1);
  endtask

  task automatic add(input logic h, input logic [10:0] hl, input logic p, input logic [10:0] rl,
      input logic c, input logic clr, input logic [1:0] wr, input logic full, input logic rdy,
      input logic [1:0] islot, input logic [10:0] ilen, input logic crdy, input logic [1:0] cslot,
      input logic [10:0] clen, input logic [2:0] occ, input logic ovf, input logic prt);
    vec_t v;
    v.h = h; v.hl = hl; v.p = p; v.rl = rl; v.c = c; v.clr = clr;
    v.wr = wr; v.full = full; v.rdy = rdy; v.islot = islot; v.ilen = ilen;
    v.crdy = crdy; v.cslot = cslot; v.clen = clen; v.occ = occ; v.ovf = ovf; v.prt = prt;
    vecs.push_back(v);
  endtask

  initial begin
    //   h  hl  p  rl  c clr   wr full rdy islot ilen crdy cslot clen occ ovf prt
    // single packet
    add(1, 12, 0,  0, 0, 0,    1, 0, 0, 0,  0, 0, 0,  0, 1, 0, 0);
    add(0,  0, 0,  0, 0, 0,    1, 0, 1, 0, 12, 0, 0,  0, 1, 0, 0);
    add(0,  0, 1,  5, 0, 0,    1, 0, 0, 0,  0, 1, 0,  5, 1, 0, 0);
    add(0,  0, 0,  0, 1, 0,    1, 0, 0, 0,  0, 0, 1,  0, 0, 0, 0);
    // fill to full, then overflow
    add(1,  1, 0,  0, 0, 0,    2, 0, 0, 0,  0, 0, 1,  0, 1, 0, 0);
    add(1,  2, 0,  0, 0, 0,    3, 0, 1, 1,  1, 0, 1,  0, 2, 0, 0);
    add(1,  3, 0,  0, 0, 0,    0, 0, 1, 1,  1, 0, 1,  0, 3, 0, 0);
    add(1,  4, 0,  0, 0, 0,    1, 1, 1, 1,  1, 0, 1,  0, 4, 0, 0);
    add(1,  9, 0,  0, 0, 0,    1, 1, 1, 1,  1, 0, 1,  0, 4, 1, 0);
    add(0,  0, 1,  7, 0, 1,    1, 1, 0, 0,  0, 1, 1,  7, 4, 0, 0);
    // overflow with same-cycle readback: still dropped
    add(1,  9, 0,  0, 1, 0,    1, 0, 1, 2,  2, 0, 2,  0, 3, 1, 0);
    add(0,  0, 0,  0, 0, 1,    1, 0, 1, 2,  2, 0, 2,  0, 3, 0, 0);
    add(1, 10, 0,  0, 0, 0,    2, 1, 1, 2,  2, 0, 2,  0, 4, 0, 0);
    add(0,  0, 1, 20, 0, 0,    2, 1, 0, 0,  0, 1, 2, 20, 4, 0, 0);
    add(0,  0, 0,  0, 1, 0,    2, 0, 1, 3,  3, 0, 3,  0, 3, 0, 0);
    add(0,  0, 1, 21, 0, 0,    2, 0, 0, 0,  0, 1, 3, 21, 3, 0, 0);
    add(0,  0, 0,  0, 0, 0,    2, 0, 1, 0,  4, 1, 3, 21, 3, 0, 0);
    add(0,  0, 0,  0, 1, 0,    2, 0, 1, 0,  4, 0, 0,  0, 2, 0, 0);
    add(0,  0, 1, 22, 0, 0,    2, 0, 0, 0,  0, 1, 0, 22, 2, 0, 0);
    add(0,  0, 0,  0, 0, 0,    2, 0, 1, 1, 10, 1, 0, 22, 2, 0, 0);
    // all three events together at occupancy 2
    add(1, 30, 1, 23, 1, 0,    3, 0, 0, 0,  0, 1, 1, 23, 2, 0, 0);
    add(0,  0, 0,  0, 0, 0,    3, 0, 1, 2, 30, 1, 1, 23, 2, 0, 0);
    add(0,  0, 0,  0, 1, 0,    3, 0, 1, 2, 30, 0, 2,  0, 1, 0, 0);
    // protocol errors and clear priority
    add(0,  0, 0,  0, 1, 0,    3, 0, 1, 2, 30, 0, 2,  0, 1, 0, 1);
    add(0,  0, 0,  0, 0, 1,    3, 0, 1, 2, 30, 0, 2,  0, 1, 0, 0);
    add(0,  0, 1, 31, 0, 0,    3, 0, 0, 0,  0, 1, 2, 31, 1, 0, 0);
    add(0,  0, 1,  0, 0, 0,    3, 0, 0, 0,  0, 1, 2, 31, 1, 0, 1);
    add(0,  0, 0,  0, 1, 1,    3, 0, 0, 0,  0, 0, 3,  0, 0, 0, 0);
    add(0,  0, 0,  0, 1, 1,    3, 0, 0, 0,  0, 0, 3,  0, 0, 0, 1);
    add(0,  0, 0,  0, 0, 1,    3, 0, 0, 0,  0, 0, 3,  0, 0, 0, 0);

    // reset state
    drive(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b0);
    sys_rst_n = 1'b0;
    #12;
    exp_q.push_back('0);
    check_word("reset_state", observe(1'b1, 1'b1));
    repeat (2) @(posedge user_clk);
    #1;
    sys_rst_n = 1'b1;
    @(posedge user_clk);
    #1;

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      exp_q.push_back(pack(v.wr, {v.wr, 10'd0}, v.full, v.rdy, v.islot, v.ilen,
                           v.crdy, v.cslot, v.clen, v.occ, v.ovf, v.prt, 1'b0));
      cycle(v.h, v.hl, v.p, v.rl, v.c, v.clr);
      check_word($sformatf("vec%0d", i), observe(v.rdy, v.crdy));
    end

    // asynchronous reset mid-packet with a pending error: everything zero,
    // no error produced afterwards
    cycle(1'b1, 11'd50, 1'b0, 11'd0, 1'b0, 1'b0);
    cycle(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b0);
    check_val("midrst_pre_rdy", {31'd0, bus.ipb_pkt_rdy}, 32'd1);
    cycle(1'b0, 11'd0, 1'b0, 11'd0, 1'b1, 1'b0);
    check_val("midrst_pre_proto", {31'd0, bus.proto_err}, 32'd1);
    #3;
    sys_rst_n = 1'b0;
    #1;
    exp_q.push_back('0);
    check_word("midrst_async", observe(1'b1, 1'b1));
    repeat (2) @(posedge user_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (2) @(posedge user_clk);
    #1;
    exp_q.push_back('0);
    check_word("midrst_after", observe(1'b1, 1'b1));

    // ring wrap: 10 packets, two in flight, slots 0,1,2,3,0,...
    cycle(1'b1, 11'd100, 1'b0, 11'd0, 1'b0, 1'b0);
    cycle(1'b1, 11'd101, 1'b0, 11'd0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      wait_rdy($sformatf("wrap%0d_rdy", k));
      check_val($sformatf("wrap%0d_islot", k), 32'(bus.ipb_slot), 32'(k % 4));
      check_val($sformatf("wrap%0d_ilen", k), 32'(bus.ipb_len), 32'(100 + k));
      cycle(1'b0, 11'd0, 1'b1, 11'(200 + k), 1'b0, 1'b0);
      check_val($sformatf("wrap%0d_gap", k), {31'd0, bus.ipb_pkt_rdy}, 32'd0);
      check_val($sformatf("wrap%0d_crdy", k), {31'd0, bus.c2h_rdy}, 32'd1);
      check_val($sformatf("wrap%0d_cslot", k), 32'(bus.c2h_slot), 32'(k % 4));
      check_val($sformatf("wrap%0d_clen", k), 32'(bus.c2h_len), 32'(200 + k));
      cycle(k + 2 < 10, 11'(102 + k), 1'b0, 11'd0, 1'b1, 1'b0);
    end
    check_val("wrap_end_occ", 32'(bus.occupancy), 32'd0);
    check_val("wrap_end_errs", {29'd0, bus.overflow_err, bus.proto_err, bus.timeout_err}, 32'd0);

`ifdef BUFFER_SLOT_TIMEOUT_EN
    begin
      int n;
      do_reset();
      cycle(1'b1, 11'd40, 1'b0, 11'd0, 1'b0, 1'b0);
      wait_rdy("tmo_rdy");
      n = 0;
      while (!bus.timeout_err && n < 24) begin
        cycle(1'b0, 11'd0, 1'b0, 11'd0, 1'b0, 1'b0);
        n++;
      end
      check_val("tmo_err", {31'd0, bus.timeout_err}, 32'd1);
      check_val("tmo_window", {31'd0, (n >= 15 && n <= 17)}, 32'd1);
      check_val("tmo_crdy", {31'd0, bus.c2h_rdy}, 32'd1);
      check_val("tmo_clen", 32'(bus.c2h_len), 32'd0);
      check_val("tmo_rdy_low", {31'd0, bus.ipb_pkt_rdy}, 32'd0);
      #3;
      sys_rst_n = 1'b0;
      #1;
      exp_q.push_back('0);
      check_word("tmo_reset", observe(1'b1, 1'b1));
      do_reset();
    end
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
